// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush control slice.
//   state_t     : controller FSM state (RUN, FLUSH; two encodings spare)
//   FLUSH_CNT_W : width of the remaining-flush-cycles register
//   STALL_CNT_W : width of the consecutive-stall watchdog counter
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

  localparam int FLUSH_CNT_W = 4;
  localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears count
//   inc   : increment request (ignored once count is all-ones)
//   clr   : synchronous clear, wins over inc
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stall_flush_controller.sv
// Pipeline stall/flush controller. Turns the load-use hazard, EXE branch
// resolution and memory-ready signals into pipeline-register control lines,
// stretches a taken-branch flush over FLUSH_CYCLES cycles, watches for
// runaway hazard stalls and keeps saturating performance counters.
//   clk           : pipeline clock
//   rst           : asynchronous active-low reset
//   hazard        : load-use hazard from the hazard detection unit
//   branch_taken  : taken branch resolved in EXE
//   mem_ready     : memory stage ready (0 = busy)
//   freeze_if     : hold PC and IF/ID
//   bubble_id     : write NOP into ID/EXE
//   flush         : clear IF/ID and ID/EXE
//   freeze_all    : hold every pipeline register
//   stall_timeout : sticky watchdog error
//   stall_count   : cycles with freeze_if=1 (saturating)
//   flush_count   : cycles with flush=1 (saturating)
module stall_flush_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             bubble_id,
  output logic             flush,
  output logic             freeze_all,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_t                 state_reg, state_next;
  logic [FLUSH_CNT_W-1:0] rem_reg, rem_next;
  logic                   freeze_if_c, bubble_id_c, flush_c;
  logic [STALL_CNT_W-1:0] run_cnt;
  logic                   run_inc, run_clr;
  logic                   stall_timeout_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // A busy memory stage overrides everything: no control line other than
  // freeze_all fires and state/rem hold, so frozen cycles never consume
  // flush cycles.
  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    freeze_if_c = 1'b0;
    bubble_id_c = 1'b0;
    flush_c     = 1'b0;
    if (mem_ready) begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              rem_next   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            end
          end else if (hazard) begin
            freeze_if_c = 1'b1;
            bubble_id_c = 1'b1;
          end
        end
        FLUSH: begin
          // Slots being flushed are bubbles, so hazard/branch are ignored.
          flush_c  = 1'b1;
          rem_next = rem_reg - FLUSH_CNT_W'(1);
          if (rem_reg == FLUSH_CNT_W'(1)) begin
            state_next = RUN;
            rem_next   = '0;
          end
        end
        default: begin
          state_next = RUN;
          rem_next   = '0;
        end
      endcase
    end
  end

  // Control lines are forced low while reset is held, independent of clock.
  assign freeze_if  = freeze_if_c & rst;
  assign bubble_id  = bubble_id_c & rst;
  assign flush      = flush_c & rst;
  assign freeze_all = ~mem_ready & rst;

  // Watchdog: counts consecutive stall cycles, stops at MAX_STALL; a
  // non-stalled active cycle clears it, a memory-frozen cycle holds it.
  assign run_inc = freeze_if_c && (run_cnt != STALL_CNT_W'(MAX_STALL));
  assign run_clr = mem_ready && !freeze_if_c;

  sat_counter #(.W(STALL_CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run_inc),
    .clr   (run_clr),
    .count (run_cnt)
  );

  // Set on the edge where run_cnt reaches MAX_STALL; sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_timeout_reg <= 1'b0;
    end else if (freeze_if_c && (run_cnt == STALL_CNT_W'(MAX_STALL - 1))) begin
      stall_timeout_reg <= 1'b1;
    end
  end

  assign stall_timeout = stall_timeout_reg;

  sat_counter #(.W(CNT_W)) u_stall_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_if_c),
    .clr   (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_c),
    .clr   (1'b0),
    .count (flush_count)
  );

endmodule
